// File: rtl/seq_alu_if.sv
// ----------------------------------------------------------------------------
// seq_alu_if
// Request/result bundle between the EX-stage issue logic and seq_alu.
//
// Signals (WIDTH = operand/result width):
//   start_i    issue request, sampled only while busy_o = 0
//   ALUCtrl_i  3-bit operation code, sampled with start_i
//   data1_i    operand A (multiplicand for mul)
//   data2_i    operand B (multiplier for mul)
//   data_o     registered result, holds until the next completion
//   zero_o     registered, 1 when data_o == 0
//   valid_o    one-cycle pulse marking a new data_o
//   busy_o     high while a multiply is iterating (pipeline stall request)
//
// Modports:
//   master  issue side (drives requests, observes results)
//   slave   the ALU itself
// ----------------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             valid_o;
  logic             busy_o;

  modport master (
    output start_i,
    output ALUCtrl_i,
    output data1_i,
    output data2_i,
    input  data_o,
    input  zero_o,
    input  valid_o,
    input  busy_o
  );

  modport slave (
    input  start_i,
    input  ALUCtrl_i,
    input  data1_i,
    input  data2_i,
    output data_o,
    output zero_o,
    output valid_o,
    output busy_o
  );

endinterface

// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu
// EX-stage ALU driven by the 3-bit ALU control code. add/sub/and/or (and the
// unused codes, which yield 0) complete in one cycle; mul runs as a radix-2
// shift-add loop and holds busy_o high until it finishes.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous reset, active-low
//   bus     seq_alu_if.slave: start_i/ALUCtrl_i/data1_i/data2_i requests,
//           data_o/zero_o/valid_o/busy_o results
//
// Parameters:
//   WIDTH   operand/result width (>= 2); must match the interface WIDTH
//
// Build option:
//   SEQ_ALU_MUL_EARLY_TERM_EN  when defined, a multiply also finishes on the
//   first iteration after which the remaining multiplier bits are all zero
//   (1..WIDTH iterations). Results are identical; only latency changes.
// ----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  seq_alu_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_valid;

  // Next-state values
  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_zero_nxt;
  logic             w_valid_nxt;

  // Combinational helpers
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_acc_sum;
  logic [WIDTH-1:0] w_mplier_shr;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_mul_done;

  // --------------------------------------------------------------------------
  // Single-cycle operations (operands taken straight from the request)
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu_res = '0;
    case (bus.ALUCtrl_i)
      OP_ADD:  w_alu_res = bus.data1_i + bus.data2_i;
      OP_SUB:  w_alu_res = bus.data1_i - bus.data2_i;
      OP_AND:  w_alu_res = bus.data1_i & bus.data2_i;
      OP_OR:   w_alu_res = bus.data1_i | bus.data2_i;
      default: w_alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift-add iteration step
  // --------------------------------------------------------------------------
  assign w_acc_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_shr = r_mplier >> 1;
  assign w_cnt_inc    = r_cnt + CNT_W'(1);

`ifdef SEQ_ALU_MUL_EARLY_TERM_EN
  // Once the shifted-out multiplier is empty no further partial product can
  // change the accumulator, so the loop may stop on this iteration.
  assign w_mul_done = (w_cnt_inc == CNT_W'(WIDTH)) || (w_mplier_shr == '0);
`else
  assign w_mul_done = (w_cnt_inc == CNT_W'(WIDTH));
`endif

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = r_data;
    w_zero_nxt   = r_zero;
    w_valid_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.ALUCtrl_i == OP_MUL) begin
            w_acc_nxt    = '0;
            w_mcand_nxt  = bus.data1_i;
            w_mplier_nxt = bus.data2_i;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_MUL;
          end else begin
            w_data_nxt  = w_alu_res;
            w_zero_nxt  = (w_alu_res == '0);
            w_valid_nxt = 1'b1;
          end
        end
      end

      S_MUL: begin
        // Requests arriving here are dropped; operands were captured at accept.
        w_acc_nxt    = w_acc_sum;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = w_mplier_shr;
        w_cnt_nxt    = w_cnt_inc;
        if (w_mul_done) begin
          w_data_nxt  = w_acc_sum;
          w_zero_nxt  = (w_acc_sum == '0);
          w_valid_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_zero   <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_zero   <= w_zero_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.data_o  = r_data;
  assign bus.zero_o  = r_zero;
  assign bus.valid_o = r_valid;
  assign bus.busy_o  = (r_state == S_MUL);

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu
// Directed and randomized checks of seq_alu against a reference model that
// computes results with plain arithmetic and multiply latency from the number
// of significant multiplier bits.
// ----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [W-1:0] ref_op(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a * b;
      default: return '0;
    endcase
  endfunction

  // Iteration edges from accept to result.
  function automatic int ref_mul_lat(input logic [W-1:0] b);
`ifdef SEQ_ALU_MUL_EARLY_TERM_EN
    int sig_bits = 0;
    for (int i = 0; i < W; i++) if (b[i]) sig_bits = i + 1;
    return (sig_bits == 0) ? 1 : sig_bits;
`else
    return W;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i   = s;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
  endtask

  // Issue a single-cycle op and check its result one edge later. start_i is
  // left asserted so callers can chain ops back to back.
  task automatic single_op(input string tag, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp;
    exp = ref_op(op, a, b);
    drive(1'b1, op, a, b);
    tick();
    check({tag, ".data"},  bus.data_o, exp);
    check({tag, ".zero"},  W'(bus.zero_o), W'(exp == '0));
    check({tag, ".valid"}, W'(bus.valid_o), W'(1));
    check({tag, ".busy"},  W'(bus.busy_o), W'(0));
  endtask

  // Issue a mul and follow it to completion. With intrude=1 an add 1+1
  // request is held on the bus for the whole busy period and left there.
  task automatic do_mul(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit intrude);
    int   edges;
    bit   busy_ok;
    logic [W-1:0] exp;
    exp = ref_op(3'd4, a, b);
    drive(1'b1, 3'd4, a, b);
    tick();
    check({tag, ".acc_busy"},  W'(bus.busy_o), W'(1));
    check({tag, ".acc_valid"}, W'(bus.valid_o), W'(0));
    if (intrude) drive(1'b1, 3'd0, W'(1), W'(1));
    else         drive(1'b0, 3'd4, $urandom, $urandom);
    edges   = 0;
    busy_ok = 1'b1;
    while (bus.valid_o !== 1'b1 && edges < 2 * W + 4) begin
      if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
      tick();
      edges++;
    end
    check({tag, ".latency"}, W'(edges), W'(ref_mul_lat(b)));
    check({tag, ".busy_held"}, W'(busy_ok), W'(1));
    check({tag, ".data"}, bus.data_o, exp);
    check({tag, ".zero"}, W'(bus.zero_o), W'(exp == '0));
    check({tag, ".busy_end"}, W'(bus.busy_o), W'(0));
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;

    rst_n = 1'b1;
    drive(1'b0, 3'd0, '0, '0);

    // Asynchronous reset asserted mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst.data",  bus.data_o, '0);
    check("rst.zero",  W'(bus.zero_o), W'(1));
    check("rst.valid", W'(bus.valid_o), W'(0));
    check("rst.busy",  W'(bus.busy_o), W'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Add 7+5, valid for exactly one cycle
    single_op("add7_5", 3'd0, W'(7), W'(5));
    drive(1'b0, 3'd0, '0, '0);
    tick();
    check("add7_5.valid_drop", W'(bus.valid_o), W'(0));
    check("add7_5.hold", bus.data_o, W'(12));

    // Back-to-back single-cycle ops
    single_op("b2b.sub",  3'd1, W'(32'hF), W'(32'hF));
    single_op("b2b.and",  3'd2, W'(32'hF), W'(32'hF));
    single_op("b2b.or",   3'd3, W'(32'hF), W'(32'hF));
    single_op("b2b.c111", 3'd7, W'(32'hF), W'(32'hF));
    drive(1'b0, 3'd0, '0, '0);
    tick();
    check("b2b.valid_drop", W'(bus.valid_o), W'(0));

    // Mul with all-ones multiplicand
    do_mul("mul_ff_2", W'(32'hFFFF_FFFF), W'(2), 1'b0);
    tick();
    check("mul_ff_2.valid_drop", W'(bus.valid_o), W'(0));

    // Busy protection: add held during mul, accepted once busy falls
    do_mul("busy_prot", W'(3), W'(4), 1'b1);
    tick();
    check("busy_prot.add.data",  bus.data_o, W'(2));
    check("busy_prot.add.valid", W'(bus.valid_o), W'(1));
    drive(1'b0, 3'd0, '0, '0);
    tick();
    check("busy_prot.valid_drop", W'(bus.valid_o), W'(0));

    // Reset at iteration 10 of a full-length mul
    drive(1'b1, 3'd4, W'(32'h1234_5678), W'(32'hFFFF_FFFF));
    tick();
    drive(1'b0, 3'd0, '0, '0);
    repeat (10) tick();
    check("rstmul.busy_pre", W'(bus.busy_o), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rstmul.busy",  W'(bus.busy_o), W'(0));
    check("rstmul.data",  bus.data_o, '0);
    check("rstmul.zero",  W'(bus.zero_o), W'(1));
    check("rstmul.valid", W'(bus.valid_o), W'(0));
    tick();
    rst_n = 1'b1;
    begin
      bit saw_valid = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
        tick();
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) saw_valid = 1'b1;
      end
      check("rstmul.quiet", W'(saw_valid), W'(0));
    end
    do_mul("mul6_7", W'(6), W'(7), 1'b0);

    // Wrap-around
    single_op("wrap.add", 3'd0, W'(32'hFFFF_FFFF), W'(1));
    single_op("wrap.sub", 3'd1, W'(0), W'(1));
    drive(1'b0, 3'd0, '0, '0);
    tick();

    // Randomized mix, including unused codes and short multipliers
    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 7) == 0) a = '0;
      if (op == 3'd4) do_mul($sformatf("rnd%0d.mul", t), a, b, 1'b0);
      else            single_op($sformatf("rnd%0d.op%0d", t, op), op, a, b);
    end
    drive(1'b0, 3'd0, '0, '0);
    tick();
    check("rnd.valid_drop", W'(bus.valid_o), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Execution-side consumer of the 3-bit ALU control code produced by the ALU control decoder.
- Performs the encoded operation on two register operands:
  - add, sub, and, or complete in one cycle.
  - mul runs iteratively (radix-2 shift-add).
- A start/valid/busy handshake lets the pipeline stall on multi-cycle multiplies.
- Sits in the EX stage in place of a purely combinational ALU.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be >= 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  request; sampled only when busy_o=0.
- ALUCtrl_i  input  3  operation code, sampled with start_i.
- data1_i  input  WIDTH  operand A (multiplicand for mul), sampled with start_i.
- data2_i  input  WIDTH  operand B (multiplier for mul), sampled with start_i.
- data_o  output  WIDTH  registered result; holds until the next completion.
- zero_o  output  1  registered; 1 when data_o==0, updated together with data_o.
- valid_o  output  1  one-cycle pulse marking a new data_o.
- busy_o  output  1  high while a mul is in progress; pipeline stall request.

Behaviour:
- Encoding of ALUCtrl_i:
  - 000 add: A+B mod 2^WIDTH.
  - 001 sub: A-B mod 2^WIDTH.
  - 010 and.
  - 011 or.
  - 100 mul: low WIDTH bits of A*B, unsigned/two's-complement-agnostic.
  - 101/110/111: result 0, single-cycle, no error flag.
- Reset (rst_i=0, asynchronous):
  - data_o=0, zero_o=1, valid_o=0, busy_o=0.
  - State=IDLE; internal accumulator, multiplicand, multiplier and counter cleared.
- States: IDLE, MUL.
- IDLE:
  - start_i=1 at edge E with a non-mul code: data_o/zero_o update at E; valid_o=1 for the cycle after E. Latency 1.
  - start_i=1 at edge E with mul: at E load acc=0, mcand=A, mplier=B, cnt=0; busy_o=1; go to MUL. valid_o stays 0.
  - start_i=0: valid_o=0; outputs hold.
- MUL, each edge:
  - If mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt++.
  - On the edge where cnt reaches WIDTH: data_o=final acc, zero_o updated, valid_o=1 for one cycle, busy_o=0, go to IDLE.
  - Mul latency: WIDTH edges after the accept edge.
- start_i while busy_o=1: ignored, not queued. Operand and code changes during MUL have no effect.
- Back-to-back issue:
  - start_i asserted in the cycle busy_o falls is accepted at the next edge.
  - Consecutive single-cycle ops accepted every cycle; valid_o stays high continuously.
- Reset mid-MUL: operation aborted; no valid_o pulse; all outputs return to reset values.
- Overflow and carry are discarded; there is no carry/overflow output.

Optional Feature:
- Macro: SEQ_ALU_MUL_EARLY_TERM_EN.
- Defined:
  - MUL also completes on the first iteration edge after which the remaining multiplier bits are all zero.
  - Minimum 1 iteration edge; maximum WIDTH.
  - Completion timing, valid_o and busy_o rules otherwise identical.
  - Example: B=5 completes after 3 iteration edges; B=0 or 1 after 1.
- Undefined: every mul takes exactly WIDTH iteration edges regardless of operands.
- Results are identical either way.

Test Plan:
- Reset, then add: rst_i low mid-cycle -> all outputs at reset values immediately. Release; add A=7, B=5 -> next cycle data_o=12, zero_o=0, valid_o=1 for exactly 1 cycle.
- Single-cycle ops back-to-back on 4 consecutive cycles, A=0x0000000F, B=0x0000000F:
  - sub -> 0, zero_o=1.
  - and -> 0xF.
  - or -> 0xF.
  - code 111 -> 0, zero_o=1.
  - valid_o high on 4 consecutive cycles; busy_o never asserted.
- Mul, WIDTH=32, A=0xFFFFFFFF, B=2:
  - busy_o high for 32 cycles.
  - data_o=0xFFFFFFFE with valid_o pulse 32 edges after accept (macro undefined).
  - With macro defined: pulse after 2 iteration edges.
- Busy protection: during a mul (A=3, B=4), assert start_i with add A=1, B=1 -> ignored; only result 12 appears. An add issued the cycle busy_o falls -> result 2 one cycle later.
- Reset mid-mul: rst_i low at iteration 10 -> busy_o=0, data_o=0, no valid_o pulse. A subsequent mul A=6, B=7 -> 42.
- Wrap: add 0xFFFFFFFF+1 -> data_o=0, zero_o=1. Sub 0-1 -> 0xFFFFFFFF, zero_o=0.
